// File: rtl/latch_loader.sv
// Serial-to-parallel front end for an 8-bit transparent output latch.
// Assembles MSB-first bytes and drives data/le/oe_n with a timed setup/strobe/hold sequence.
module latch_loader #(
    parameter int SETUP_CYC = 1,
    parameter int LE_WIDTH  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    input  logic       ser_valid,
    input  logic       frame_start,
    input  logic       out_en,
    input  logic       ovr_clr,
    output logic [7:0] data_out,
    output logic       le,
    output logic       oe_n,
    output logic       busy,
    output logic       byte_done,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int MAXC  = (SETUP_CYC > LE_WIDTH) ? SETUP_CYC : LE_WIDTH;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    logic [7:0]       sreg_q, sreg_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       data_q, data_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             le_q, le_d;
    logic             oe_n_q, oe_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             byte_cmp_s;
    logic             accept_s;
    logic             drop_s;

    // A realigning frame_start makes the sampled bit the first of a new byte, never the last.
    assign byte_cmp_s = ser_valid & ~frame_start & (bit_cnt_q == 3'd7);
    // HOLD is the final cycle of a sequence, so a byte landing there can start the next one.
    assign accept_s   = byte_cmp_s & ((state_q == IDLE) | (state_q == HOLD));
    assign drop_s     = byte_cmp_s & ~accept_s;

    // Shift register and bit counter, independent of the strobe FSM.
    always_comb begin
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        if (ser_valid) begin
            sreg_d    = {sreg_q[6:0], ser_in};
            bit_cnt_d = frame_start ? 3'd1 : (bit_cnt_q + 3'd1);
        end else if (frame_start) begin
            bit_cnt_d = 3'd0;
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Strobe FSM next-state and per-state cycle counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == CNT_W'(LE_WIDTH - 1)) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                cnt_d   = '0;
                state_d = accept_s ? SETUP : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output next-values, decoded from the next state so every output is a flop.
    always_comb begin
        le_d   = (state_d == STROBE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == HOLD);
        oe_n_d = ~out_en;
        data_d = accept_s ? {sreg_q[6:0], ser_in} : data_q;
        if (drop_s) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q    <= 8'h00;
            bit_cnt_q <= 3'd0;
            data_q    <= 8'h00;
            state_q   <= IDLE;
            cnt_q     <= '0;
            le_q      <= 1'b0;
            oe_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            le_q      <= le_d;
            oe_n_q    <= oe_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign le        = le_q;
    assign oe_n      = oe_n_q;
    assign busy      = busy_q;
    assign byte_done = done_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_latch_loader.sv
// Directed bench for latch_loader: three instances (S=4, S=8, S=10) share one stimulus stream.
module tb_latch_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ser_in = 1'b0;
    logic ser_valid = 1'b0;
    logic frame_start = 1'b0;
    logic out_en = 1'b0;
    logic ovr_clr = 1'b0;

    logic [7:0] a_data, b_data, c_data;
    logic a_le, a_oe_n, a_busy, a_done, a_ovr;
    logic b_le, b_oe_n, b_busy, b_done, b_ovr;
    logic c_le, c_oe_n, c_busy, c_done, c_ovr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    latch_loader u_a (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
        .frame_start(frame_start), .out_en(out_en), .ovr_clr(ovr_clr),
        .data_out(a_data), .le(a_le), .oe_n(a_oe_n), .busy(a_busy),
        .byte_done(a_done), .overrun(a_ovr)
    );

    latch_loader #(.SETUP_CYC(3), .LE_WIDTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
        .frame_start(frame_start), .out_en(out_en), .ovr_clr(ovr_clr),
        .data_out(b_data), .le(b_le), .oe_n(b_oe_n), .busy(b_busy),
        .byte_done(b_done), .overrun(b_ovr)
    );

    latch_loader #(.SETUP_CYC(3), .LE_WIDTH(6)) u_c (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(ser_valid),
        .frame_start(frame_start), .out_en(out_en), .ovr_clr(ovr_clr),
        .data_out(c_data), .le(c_le), .oe_n(c_oe_n), .busy(c_busy),
        .byte_done(c_done), .overrun(c_ovr)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ser_in    = b;
        ser_valid = 1'b1;
        tick();
        ser_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    initial begin
        logic [7:0] second;
        second = 8'hC3;

        // reset state
        #12;
        chk("rst_data", a_data, 8'h00);
        chk("rst_le", {7'd0, a_le}, 8'h00);
        chk("rst_oe_n", {7'd0, a_oe_n}, 8'h01);
        chk("rst_busy", {7'd0, a_busy}, 8'h00);
        chk("rst_done", {7'd0, a_done}, 8'h00);
        chk("rst_ovr", {7'd0, a_ovr}, 8'h00);
        rst_n = 1'b1;
        tick();

        // single byte A5, default timing (S=4)
        send_byte(8'hA5);
        chk("a5_data", a_data, 8'hA5);
        chk("a5_busy_t0", {7'd0, a_busy}, 8'h01);
        chk("a5_le_t0", {7'd0, a_le}, 8'h00);
        tick();
        chk("a5_le_t1", {7'd0, a_le}, 8'h01);
        tick();
        chk("a5_le_t2", {7'd0, a_le}, 8'h01);
        chk("a5_done_t2", {7'd0, a_done}, 8'h00);
        tick();
        chk("a5_le_t3", {7'd0, a_le}, 8'h00);
        chk("a5_done_t3", {7'd0, a_done}, 8'h01);
        chk("a5_busy_t3", {7'd0, a_busy}, 8'h01);
        tick();
        chk("a5_busy_t4", {7'd0, a_busy}, 8'h00);
        chk("a5_done_t4", {7'd0, a_done}, 8'h00);
        repeat (8) tick();

        // back-to-back 3C then C3 at full rate
        send_byte(8'h3C);
        chk("b2b_b_data0", b_data, 8'h3C);
        chk("b2b_c_data0", c_data, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            send_bit(second[7-i]);
            if (i == 2) begin
                chk("b2b_b_le_t3", {7'd0, b_le}, 8'h01);
                chk("b2b_b_latch1", b_data, 8'h3C);
            end
            if (i == 6) begin
                chk("b2b_b_done_t7", {7'd0, b_done}, 8'h01);
                chk("b2b_c_le_t7", {7'd0, c_le}, 8'h01);
            end
        end
        chk("b2b_b_data1", b_data, 8'hC3);
        chk("b2b_a_data1", a_data, 8'hC3);
        chk("b2b_b_busy_t8", {7'd0, b_busy}, 8'h01);
        chk("b2b_c_ovr", {7'd0, c_ovr}, 8'h01);
        chk("b2b_c_data_kept", c_data, 8'h3C);
        repeat (3) tick();
        chk("b2b_b_le_t11", {7'd0, b_le}, 8'h01);
        chk("b2b_b_latch2", b_data, 8'hC3);
        repeat (4) tick();
        chk("b2b_b_done_t15", {7'd0, b_done}, 8'h01);
        chk("b2b_b_ovr", {7'd0, b_ovr}, 8'h00);
        chk("b2b_a_ovr", {7'd0, a_ovr}, 8'h00);
        chk("b2b_c_ovr_sticky", {7'd0, c_ovr}, 8'h01);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr", {7'd0, c_ovr}, 8'h00);
        chk("ovr_clr_data", c_data, 8'h3C);
        repeat (4) tick();

        // frame_start realignment: 3 stale bits, then 8'h81
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        frame_start = 1'b1;
        send_bit(1'b1);
        frame_start = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        chk("frm_no_stale", {7'd0, a_busy}, 8'h00);
        send_bit(1'b1);
        chk("frm_data", a_data, 8'h81);
        chk("frm_busy", {7'd0, a_busy}, 8'h01);
        repeat (12) tick();

        // oe_n follows out_en with one cycle of latency
        out_en = 1'b1;
        #2;
        chk("oe_pre", {7'd0, a_oe_n}, 8'h01);
        tick();
        chk("oe_on", {7'd0, a_oe_n}, 8'h00);
        out_en = 1'b0;
        #2;
        chk("oe_hold", {7'd0, a_oe_n}, 8'h00);
        tick();
        chk("oe_off", {7'd0, a_oe_n}, 8'h01);

        // async reset while in STROBE, with a partial byte in flight
        out_en = 1'b1;
        send_byte(8'h5A);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("rs_in_strobe", {7'd0, a_le}, 8'h01);
        chk("rs_oe_before", {7'd0, a_oe_n}, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_le", {7'd0, a_le}, 8'h00);
        chk("rs_busy", {7'd0, a_busy}, 8'h00);
        chk("rs_done", {7'd0, a_done}, 8'h00);
        chk("rs_oe_n", {7'd0, a_oe_n}, 8'h01);
        chk("rs_data", a_data, 8'h00);
        chk("rs_b_le", {7'd0, b_le}, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        chk("rs_partial_lost", {7'd0, a_busy}, 8'h00);
        send_bit(1'b1);
        chk("rs_ff_data", a_data, 8'hFF);
        tick();
        chk("rs_ff_le", {7'd0, a_le}, 8'h01);
        repeat (2) tick();
        chk("rs_ff_done", {7'd0, a_done}, 8'h01);
        tick();
        chk("rs_ff_idle", {7'd0, a_busy}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
